// File: rtl/rise_event_arbiter.sv
// Rising-edge event detector with a round-robin report channel.
// Each input rise becomes a pending event offered one at a time over a valid/ready handshake.
module rise_event_arbiter #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         a,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [$clog2(N)-1:0] evt_id,
  output logic [N-1:0]         ovf,
  input  logic [N-1:0]         ovf_clr,
  output logic [CNT_W-1:0]     evt_cnt
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  state_t            state_reg;
  logic [N-1:0]      prev_a_reg;
  logic [N-1:0]      pending_reg;
  logic [N-1:0]      pending_next;
  logic [N-1:0]      ovf_reg;
  logic [N-1:0]      ovf_next;
  logic [N-1:0]      rise;
  logic [N-1:0]      clr_vec;
  logic              evt_valid_reg;
  logic [IW-1:0]     evt_id_reg;
  logic [IW-1:0]     last_grant_reg;
  logic [CNT_W-1:0]  evt_cnt_reg;
  logic              handshake;
  logic              grant_found;
  logic [IW-1:0]     grant_idx;
  logic [IW:0]       cand_sum [N];
  logic [IW-1:0]     cand_idx [N];

  assign handshake = evt_valid_reg & evt_ready;

  // Per-signal bookkeeping: a new rise always wins over a same-cycle clear.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign rise[gi]         = a[gi] & ~prev_a_reg[gi];
      assign clr_vec[gi]      = handshake && (evt_id_reg == IW'(gi));
      assign pending_next[gi] = (pending_reg[gi] & ~clr_vec[gi]) | rise[gi];
      assign ovf_next[gi]     = (rise[gi] & pending_reg[gi] & ~clr_vec[gi])
                              | (ovf_reg[gi] & ~ovf_clr[gi]);
    end
  endgenerate

  // Candidate k is the k-th index after last_grant, wrapped modulo N.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      assign cand_sum[gi] = {1'b0, last_grant_reg} + (IW + 1)'(gi + 1);
      assign cand_idx[gi] = (cand_sum[gi] >= (IW + 1)'(N))
                          ? IW'(cand_sum[gi] - (IW + 1)'(N))
                          : IW'(cand_sum[gi]);
    end
  endgenerate

  // Scan from the farthest candidate back so the nearest pending one wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (pending_reg[cand_idx[k]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_a_reg  <= '0;
      pending_reg <= '0;
      ovf_reg     <= '0;
    end else begin
      prev_a_reg  <= a;
      pending_reg <= pending_next;
      ovf_reg     <= ovf_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      evt_valid_reg  <= 1'b0;
      evt_id_reg     <= '0;
      last_grant_reg <= LAST_IDX;
      evt_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            evt_id_reg    <= grant_idx;
            evt_valid_reg <= 1'b1;
            state_reg     <= OFFER;
          end
        end
        OFFER: begin
          if (evt_ready) begin
            last_grant_reg <= evt_id_reg;
            evt_valid_reg  <= 1'b0;
            state_reg      <= IDLE;
            if (evt_cnt_reg != {CNT_W{1'b1}}) begin
              evt_cnt_reg <= evt_cnt_reg + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign evt_valid = evt_valid_reg;
  assign evt_id    = evt_id_reg;
  assign ovf       = ovf_reg;
  assign evt_cnt   = evt_cnt_reg;

endmodule
